// File: rtl/conv_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_sched
// Brief    : Walks layer / output position / kernel / tap for the shared conv
//            MAC engine and issues clear, bias-add and write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_sched #(
    parameter int NUM_LAYERS  = 5,
    parameter int MAX_KERNELS = 64,
    parameter int MAX_DEPTH   = 64,
    parameter int TILE        = 3,
    localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int WAW = $clog2(NUM_LAYERS * MAX_KERNELS * MAX_DEPTH * 9),
    localparam int BAW = $clog2(NUM_LAYERS * MAX_KERNELS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic [LW-1:0]  cfg_layer,
    input  logic [6:0]     cfg_kernels,
    input  logic [6:0]     cfg_depth,
    output logic           acc_clr,
    output logic           mac_valid,
    input  logic           mac_ready,
    output logic [WAW-1:0] tap_waddr,
    output logic [1:0]     tap_i,
    output logic [1:0]     tap_j,
    output logic [5:0]     tap_d,
    output logic [1:0]     tap_ki,
    output logic [1:0]     tap_kj,
    output logic           bias_add,
    output logic [BAW-1:0] bias_addr,
    output logic           wr_en,
    output logic [LW-1:0]  wr_layer,
    output logic [1:0]     wr_i,
    output logic [1:0]     wr_j,
    output logic [5:0]     wr_kernel,
    output logic           layer_done,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0]    c_TILE_LAST  = 2'(TILE - 1);
    localparam logic [LW-1:0] c_LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [6:0]    c_KMAX       = 7'(MAX_KERNELS);
    localparam logic [6:0]    c_DMAX       = 7'(MAX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [LW-1:0]   r_layer;
    logic [1:0]      r_i;
    logic [1:0]      r_j;
    logic [5:0]      r_kernel;
    logic [5:0]      r_d;
    logic [1:0]      r_ki;
    logic [1:0]      r_kj;
    logic            r_layer_done;

    logic [6:0]      w_kernels;
    logic [6:0]      w_depth;
    logic            w_skip;
    logic            w_last_tap;
    logic            w_last_kernel;
    logic            w_last_out;
    logic            w_last_layer;

    assign w_kernels     = (cfg_kernels > c_KMAX) ? c_KMAX : cfg_kernels;
    assign w_depth       = (cfg_depth > c_DMAX) ? c_DMAX : cfg_depth;
    assign w_skip        = (r_state == S_CLEAR) && (w_kernels == 7'd0);
    assign w_last_tap    = (r_kj == 2'd2) && (r_ki == 2'd2) && ({1'b0, r_d} == w_depth - 7'd1);
    assign w_last_kernel = ({1'b0, r_kernel} == w_kernels - 7'd1);
    assign w_last_out    = w_last_kernel && (r_i == c_TILE_LAST) && (r_j == c_TILE_LAST);
    assign w_last_layer  = (r_layer == c_LAST_LAYER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An empty layer spends its CLEAR slot with acc_clr held low; cfg is
    // stable for the whole layer, so the gate never glitches mid-layer.
    always_comb begin
        w_state_next = r_state;
        acc_clr      = 1'b0;
        mac_valid    = 1'b0;
        bias_add     = 1'b0;
        wr_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                acc_clr = !w_skip;
                if (w_skip)                  w_state_next = w_last_layer ? S_DONE : S_CLEAR;
                else if (w_depth == 7'd0)    w_state_next = S_BIAS;
                else                         w_state_next = S_MAC;
            end
            S_MAC: begin
                mac_valid = 1'b1;
                if (mac_ready && w_last_tap) w_state_next = S_BIAS;
            end
            S_BIAS: begin
                bias_add     = 1'b1;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_en        = 1'b1;
                w_state_next = (w_last_out && w_last_layer) ? S_DONE : S_CLEAR;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_layer      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_kernel     <= '0;
            r_d          <= '0;
            r_ki         <= '0;
            r_kj         <= '0;
            r_layer_done <= 1'b0;
        end else begin
            r_layer_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_layer  <= '0;
                    r_i      <= '0;
                    r_j      <= '0;
                    r_kernel <= '0;
                    r_d      <= '0;
                    r_ki     <= '0;
                    r_kj     <= '0;
                end
                S_CLEAR: begin
                    if (w_skip) begin
                        r_layer_done <= 1'b1;
                        r_layer      <= w_last_layer ? '0 : r_layer + LW'(1);
                    end
                end
                S_MAC: begin
                    if (mac_ready) begin
                        if (r_kj == 2'd2) begin
                            r_kj <= 2'd0;
                            if (r_ki == 2'd2) begin
                                r_ki <= 2'd0;
                                r_d  <= w_last_tap ? 6'd0 : r_d + 6'd1;
                            end else begin
                                r_ki <= r_ki + 2'd1;
                            end
                        end else begin
                            r_kj <= r_kj + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_kernel) begin
                        r_kernel <= 6'd0;
                        if (r_j == c_TILE_LAST) begin
                            r_j <= 2'd0;
                            if (r_i == c_TILE_LAST) begin
                                r_i          <= 2'd0;
                                r_layer_done <= 1'b1;
                                r_layer      <= w_last_layer ? '0 : r_layer + LW'(1);
                            end else begin
                                r_i <= r_i + 2'd1;
                            end
                        end else begin
                            r_j <= r_j + 2'd1;
                        end
                    end else begin
                        r_kernel <= r_kernel + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_layer  = r_layer;
    assign tap_waddr  = WAW'(((32'(r_layer) * 32'(MAX_KERNELS) + 32'(r_kernel)) * 32'(MAX_DEPTH)
                              + 32'(r_d)) * 32'd9 + 32'(r_ki) * 32'd3 + 32'(r_kj));
    assign bias_addr  = BAW'(32'(r_layer) * 32'(MAX_KERNELS) + 32'(r_kernel));
    assign tap_i      = r_i;
    assign tap_j      = r_j;
    assign tap_d      = r_d;
    assign tap_ki     = r_ki;
    assign tap_kj     = r_kj;
    assign wr_layer   = r_layer;
    assign wr_i       = r_i;
    assign wr_j       = r_j;
    assign wr_kernel  = r_kernel;
    assign layer_done = r_layer_done;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_sched
// Brief    : Self-checking bench; a loop-nest model predicts the event stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sched;

    localparam int EV_NONE = 0, EV_LD = 1, EV_DONE = 2, EV_CLR = 3, EV_TAP = 4, EV_BIAS = 5, EV_WR = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mac_ready = 1'b1;
    logic [2:0]  cfg_layer;
    logic [6:0]  cfg_kernels, cfg_depth;
    logic        acc_clr, mac_valid, bias_add, wr_en, layer_done, busy, done;
    logic [17:0] tap_waddr;
    logic [1:0]  tap_i, tap_j, tap_ki, tap_kj, wr_i, wr_j;
    logic [5:0]  tap_d, wr_kernel;
    logic [8:0]  bias_addr;
    logic [2:0]  wr_layer;

    logic [6:0]  tb_k [8];
    logic [6:0]  tb_d [8];
    assign cfg_kernels = tb_k[cfg_layer];
    assign cfg_depth   = tb_d[cfg_layer];

    conv_layer_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_layer(cfg_layer), .cfg_kernels(cfg_kernels), .cfg_depth(cfg_depth),
        .acc_clr(acc_clr), .mac_valid(mac_valid), .mac_ready(mac_ready),
        .tap_waddr(tap_waddr), .tap_i(tap_i), .tap_j(tap_j), .tap_d(tap_d),
        .tap_ki(tap_ki), .tap_kj(tap_kj), .bias_add(bias_add), .bias_addr(bias_addr),
        .wr_en(wr_en), .wr_layer(wr_layer), .wr_i(wr_i), .wr_j(wr_j), .wr_kernel(wr_kernel),
        .layer_done(layer_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0       = 0;
    bit mon_en   = 1'b0;
    bit timed_en = 1'b0;
    bit rdy_rnd  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) mac_ready = rdy_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;

    typedef struct {
        int          kind;
        logic [63:0] val;
        int          cyc;
        int          lay, ker, dd, ki, kj;
    } ev_t;
    ev_t exp_q[$];

    logic [31:0] cur_idx;
    logic [63:0] all_outs;
    logic [5:0]  strobes;
    assign cur_idx  = {tap_i, tap_j, tap_d, tap_ki, tap_kj, tap_waddr};
    assign strobes  = {acc_clr, mac_valid, bias_add, wr_en, layer_done, done};
    assign all_outs = {cfg_layer, acc_clr, mac_valid, tap_waddr, tap_i, tap_j, tap_d, tap_ki, tap_kj,
                       bias_add, bias_addr, wr_en, wr_layer, wr_i, wr_j, wr_kernel, layer_done, busy, done};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc - c0);
        end
    endtask

    task automatic set_cfg(input int l, input int k, input int d);
        tb_k[l] = 7'(k);
        tb_d[l] = 7'(d);
    endtask

    function automatic void push_ev(input int kind, input logic [63:0] val, input int t,
                                    input int l, input int k, input int d, input int ki, input int kj);
        ev_t e;
        e.kind = kind; e.val = val; e.cyc = t;
        e.lay = l; e.ker = k; e.dd = d; e.ki = ki; e.kj = kj;
        exp_q.push_back(e);
    endfunction

    // Reference: the specified loop nest, with cycle t counted from the start edge.
    function automatic void build_model();
        int t = 1;
        exp_q.delete();
        for (int l = 0; l < 5; l++) begin
            int kc = (int'(tb_k[l]) > 64) ? 64 : int'(tb_k[l]);
            int dc = (int'(tb_d[l]) > 64) ? 64 : int'(tb_d[l]);
            if (kc == 0) begin
                t++;
                push_ev(EV_LD, 64'd0, t, l, 0, 0, 0, 0);
                continue;
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    for (int k = 0; k < kc; k++) begin
                        push_ev(EV_CLR, 64'd0, t, l, k, 0, 0, 0);
                        t++;
                        for (int d = 0; d < dc; d++)
                            for (int ki = 0; ki < 3; ki++)
                                for (int kj = 0; kj < 3; kj++) begin
                                    int wa = ((l * 64 + k) * 64 + d) * 9 + ki * 3 + kj;
                                    push_ev(EV_TAP, 64'({2'(i), 2'(j), 6'(d), 2'(ki), 2'(kj), 18'(wa)}),
                                            t, l, k, d, ki, kj);
                                    t++;
                                end
                        push_ev(EV_BIAS, 64'(l * 64 + k), t, l, k, 0, 0, 0);
                        t++;
                        push_ev(EV_WR, 64'({3'(l), 2'(i), 2'(j), 6'(k)}), t, l, k, 0, 0, 0);
                        t++;
                    end
            push_ev(EV_LD, 64'd0, t, l, 0, 0, 0, 0);
        end
        push_ev(EV_DONE, 64'd0, t, 0, 0, 0, 0, 0);
    endfunction

    task automatic expect_ev(input int kind, input string tag, input logic [63:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq({"unexpected_", tag}, 64'(kind), 64'(EV_NONE));
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_kind"}, 64'(kind), 64'(e.kind));
        check_eq(tag, val, e.val);
        if (timed_en) check_eq({tag, "_cycle"}, 64'(cyc - c0), 64'(e.cyc));
        if (kind == EV_TAP && e.lay == 1 && e.ker == 3 && e.dd == 2 && e.ki == 1 && e.kj == 2)
            check_eq("waddr_l1k3d2", 64'(tap_waddr), 64'd38615);
        if (kind == EV_BIAS && e.lay == 1 && e.ker == 3)
            check_eq("bias_addr_l1k3", 64'(bias_addr), 64'd67);
    endtask

    bit          prev_stall = 1'b0;
    logic [31:0] prev_idx   = '0;

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (prev_stall) begin
                check_eq("stall_valid_hold", 64'(mac_valid), 64'd1);
                check_eq("stall_idx_hold", 64'(cur_idx), 64'(prev_idx));
            end
            if (layer_done)             expect_ev(EV_LD, "layer_done", 64'd0);
            if (done)                   expect_ev(EV_DONE, "done", 64'd0);
            if (acc_clr)                expect_ev(EV_CLR, "acc_clr", 64'd0);
            if (mac_valid && mac_ready) expect_ev(EV_TAP, "tap", 64'(cur_idx));
            if (bias_add)               expect_ev(EV_BIAS, "bias", 64'(bias_addr));
            if (wr_en)                  expect_ev(EV_WR, "write", 64'({wr_layer, wr_i, wr_j, wr_kernel}));
            prev_stall = mac_valid && !mac_ready;
            prev_idx   = cur_idx;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_run(input bit timed, input bit rnd, input bit extra_start);
        int n = 0;
        bit fin = 1'b0;
        build_model();
        timed_en = timed;
        rdy_rnd  = rnd;
        @(negedge clk);
        c0     = cyc;
        start  = 1'b1;
        mon_en = 1'b1;
        while (!fin && n < 20000) begin
            @(negedge clk);
            n++;
            start = extra_start && (cyc - c0 == 5);
            #2;
            if (exp_q.size() == 0) fin = 1'b1;
        end
        start = 1'b0;
        check_eq("run_events_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        #2;
        check_eq("busy_after_done", 64'(busy), 64'd0);
        check_eq("done_after_done", 64'(done), 64'd0);
        mon_en  = 1'b0;
        rdy_rnd = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        for (int l = 0; l < 8; l++) set_cfg(l, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check_eq("reset_all_outputs", all_outs, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_cfg_layer", 64'(cfg_layer), 64'd0);
        check_eq("idle_strobes", 64'(strobes), 64'd0);

        // Mixed geometry incl. empty layer and depth 0; start while busy ignored
        set_cfg(0, 2, 1); set_cfg(1, 4, 3); set_cfg(2, 0, 5); set_cfg(3, 1, 0); set_cfg(4, 3, 2);
        do_run(1'b1, 1'b0, 1'b1);

        // Abort during MAC, then restart from layer 0
        set_cfg(0, 2, 1); set_cfg(1, 1, 0); set_cfg(2, 1, 1); set_cfg(3, 0, 0); set_cfg(4, 0, 0);
        @(negedge clk);
        c0    = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc - c0 < 20) @(negedge clk);
        #2;
        check_eq("abort_in_mac", 64'(mac_valid), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_strobes", 64'(strobes), 64'd0);
        repeat (3) begin
            @(negedge clk);
            #2;
            check_eq("abort_no_done", 64'(done), 64'd0);
            check_eq("abort_stays_idle", 64'(busy), 64'd0);
        end
        do_run(1'b1, 1'b0, 1'b0);

        // Over-range configuration clamps to maxima
        set_cfg(0, 100, 0); set_cfg(1, 1, 100); set_cfg(2, 0, 0); set_cfg(3, 0, 0); set_cfg(4, 1, 1);
        do_run(1'b1, 1'b0, 1'b0);

        // Randomised geometry with random backpressure, then one timed
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 5; l++) set_cfg(l, $urandom_range(0, 3), $urandom_range(0, 3));
            do_run(r == 3, r != 3, 1'b0);
        end

        // Reset pulse during a BIAS cycle of layer 1
        set_cfg(0, 1, 1); set_cfg(1, 1, 1); set_cfg(2, 1, 1); set_cfg(3, 1, 1); set_cfg(4, 1, 1);
        @(negedge clk);
        c0    = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            #2;
            if (bias_add && cfg_layer == 3'd1) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("bias_l1_reached", 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_eq("midrun_reset_outputs", all_outs, 64'd0);
        @(negedge clk);
        #2;
        check_eq("post_reset_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
